// File: rtl/sysctrl_gen.sv
// System controller for the MCU link: decodes byte-serial commands, drives
// LEDs/colour, holds config variables, bridges the IO ports and raises the
// shared interrupt.
module sysctrl_gen #(
  parameter logic [7:0] CORE_ID   = 8'h00,
  parameter int         NUM_PORTS = 2,
  parameter int         NUM_VARS  = 16,
  parameter int         MENU_AW   = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   data_in_strobe,
  input  logic                   data_in_start,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  output logic                   int_out_n,
  input  logic [7:0]             int_in,
  output logic [7:0]             int_ack,
  input  logic [1:0]             buttons,
  output logic [1:0]             leds,
  output logic [23:0]            color,
  input  logic [32*NUM_PORTS-1:0] port_status,
  input  logic [8*NUM_PORTS-1:0] port_out_available,
  input  logic [8*NUM_PORTS-1:0] port_out_data,
  input  logic [8*NUM_PORTS-1:0] port_in_available,
  output logic [NUM_PORTS-1:0]   port_out_strobe,
  output logic [NUM_PORTS-1:0]   port_in_strobe,
  output logic [7:0]             port_in_data,
  output logic [MENU_AW-1:0]     menu_addr,
  input  logic [7:0]             menu_data,
  output logic [8*NUM_VARS-1:0]  cfg_vars
);

  // Variables "A" (index 0) and "D" (index 3) power up as 1, the rest as 0.
  function automatic logic [8*NUM_VARS-1:0] cfg_default();
    logic [8*NUM_VARS-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_VARS; k++)
      if (k == 0 || k == 3) v[8*k +: 8] = 8'h01;
    return v;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  localparam logic [8*NUM_VARS-1:0] CFG_RESET = cfg_default();
  localparam logic [MENU_AW-1:0]    MENU_ONE  = 1;

  logic [7:0]           command, byte_cnt, cmd_id, sub_cmd, port_sel;
  logic                 coldboot, sys_int, btn_irq_en;
  logic [1:0]           btn_s1, btn_s2;
  logic [NUM_PORTS-1:0] avail_nz, avail_nz_d;
  logic [3:0]           avail_mask;
  logic [7:0]           sel_out_avail, sel_in_avail, sel_out_data;
  logic [31:0]          sel_status;
  logic [7:0]           resp, var_idx;
  logic                 port_ok, var_ok, btn_evt, irq_set;
  logic                 unused_int0;

  assign unused_int0 = int_in[0];
  assign port_ok     = port_sel < 8'(NUM_PORTS);
  assign var_idx     = cmd_id - 8'h41;
  assign var_ok      = (cmd_id >= 8'h41) && (var_idx < 8'(NUM_VARS));
  assign btn_evt     = btn_irq_en && (btn_s1 != btn_s2);
  assign irq_set     = (|(avail_nz & ~avail_nz_d)) || btn_evt;
  assign int_out_n   = ~(sys_int || (|int_in[7:1]));

  // Per-port availability flags and the selected port's fields.
  always_comb begin
    avail_nz      = '0;
    avail_mask    = '0;
    sel_out_avail = '0;
    sel_in_avail  = '0;
    sel_out_data  = '0;
    sel_status    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      avail_nz[i] = |port_out_available[8*i +: 8];
      if (port_sel == 8'(i)) begin
        sel_out_avail = port_out_available[8*i +: 8];
        sel_in_avail  = port_in_available[8*i +: 8];
        sel_out_data  = port_out_data[8*i +: 8];
        sel_status    = port_status[32*i +: 32];
      end
    end
    avail_mask[NUM_PORTS-1:0] = avail_nz;
  end

  // Response byte for the current command and byte position.
  always_comb begin
    resp = 8'h00;
    case (command)
      8'h00: begin
        case (byte_cnt)
          8'd0:    resp = 8'h5C;
          8'd1:    resp = 8'h42;
          8'd2:    resp = CORE_ID;
          default: resp = 8'h00;
        endcase
      end
      8'h03: resp = {6'b0, buttons};
      8'h05: resp = {int_in[7:1], sys_int};
      8'h06: resp = {avail_mask, 1'b0, ~btn_irq_en, |avail_mask, coldboot};
      8'h07: begin
        if (byte_cnt == 8'd0) resp = 8'(NUM_PORTS);
        else if (byte_cnt >= 8'd2 && port_ok) begin
          if (sub_cmd == 8'd0) begin
            case (byte_cnt)
              8'd2:    resp = sel_out_avail;
              8'd3:    resp = sel_in_avail;
              8'd4:    resp = sel_status[31:24];
              8'd5:    resp = sel_status[23:16];
              8'd6:    resp = sel_status[15:8];
              8'd7:    resp = sel_status[7:0];
              default: resp = 8'h00;
            endcase
          end else if (sub_cmd == 8'd1) resp = sel_out_data;
        end
      end
      8'h08:   resp = menu_data;
      default: resp = 8'h00;
    endcase
  end

  // Command execution, interrupt tracking and one-clock strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      command         <= 8'hFF;  // no command active until the next start byte
      byte_cnt        <= '0;
      cmd_id          <= '0;
      sub_cmd         <= '0;
      port_sel        <= '0;
      data_out        <= '0;
      leds            <= '0;
      color           <= '0;
      int_ack         <= '0;
      port_out_strobe <= '0;
      port_in_strobe  <= '0;
      port_in_data    <= '0;
      menu_addr       <= '0;
      cfg_vars        <= CFG_RESET;
      coldboot        <= 1'b1;
      sys_int         <= 1'b1;
      btn_irq_en      <= 1'b1;
      btn_s1          <= '0;
      btn_s2          <= '0;
      avail_nz_d      <= '0;
    end else begin
      int_ack         <= '0;
      port_out_strobe <= '0;
      port_in_strobe  <= '0;
      btn_s1          <= buttons;
      btn_s2          <= btn_s1;
      avail_nz_d      <= avail_nz;
      if (irq_set) sys_int <= 1'b1;
      else if (int_ack[0]) sys_int <= 1'b0;
      if (btn_evt) btn_irq_en <= 1'b0;

      if (data_in_strobe) begin
        if (data_in_start) begin
          command   <= data_in;
          byte_cnt  <= '0;
          menu_addr <= '0;
          data_out  <= '0;
        end else begin
          data_out <= resp;
          if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
          case (command)
            8'h01: if (byte_cnt == 8'd0) leds <= data_in[1:0];
            8'h02: begin
              if (byte_cnt == 8'd0) color[15:8]  <= rev8(data_in);
              if (byte_cnt == 8'd1) color[7:0]   <= rev8(data_in);
              if (byte_cnt == 8'd2) color[23:16] <= rev8(data_in);
            end
            8'h03: btn_irq_en <= 1'b1;
            8'h04: begin
              if (byte_cnt == 8'd0) cmd_id <= data_in;
              else if (byte_cnt == 8'd1 && var_ok)
                for (int k = 0; k < NUM_VARS; k++)
                  if (var_idx == 8'(k)) cfg_vars[8*k +: 8] <= data_in;
            end
            8'h05: if (byte_cnt == 8'd0) int_ack <= data_in;
            8'h06: if (byte_cnt == 8'd0) coldboot <= 1'b0;
            8'h07: begin
              if (byte_cnt == 8'd0) sub_cmd <= data_in;
              else if (byte_cnt == 8'd1) port_sel <= data_in;
              else if (port_ok) begin
                if (sub_cmd == 8'd1 && data_in[0])
                  for (int i = 0; i < NUM_PORTS; i++)
                    port_out_strobe[i] <= (port_sel == 8'(i));
                if (sub_cmd == 8'd2) begin
                  port_in_data <= data_in;
                  for (int i = 0; i < NUM_PORTS; i++)
                    port_in_strobe[i] <= (port_sel == 8'(i));
                end
              end
            end
            8'h08: menu_addr <= menu_addr + MENU_ONE;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sysctrl_gen.sv
// Directed-plus-random bench for sysctrl_gen against a small behavioural model.
module tb_sysctrl_gen;
  localparam int         NP  = 2;
  localparam int         NV  = 16;
  localparam int         AW  = 10;
  localparam logic [7:0] CID = 8'h07;

  logic            clk = 1'b0;
  logic            reset;
  logic            data_in_strobe, data_in_start;
  logic [7:0]      data_in, data_out;
  logic            int_out_n;
  logic [7:0]      int_in, int_ack;
  logic [1:0]      buttons, leds;
  logic [23:0]     color;
  logic [32*NP-1:0] port_status;
  logic [8*NP-1:0] port_out_available, port_out_data, port_in_available;
  logic [NP-1:0]   port_out_strobe, port_in_strobe;
  logic [7:0]      port_in_data;
  logic [AW-1:0]   menu_addr;
  logic [7:0]      menu_data;
  logic [8*NV-1:0] cfg_vars;

  always #5 clk = ~clk;

  sysctrl_gen #(.CORE_ID(CID), .NUM_PORTS(NP), .NUM_VARS(NV), .MENU_AW(AW)) dut (
    .clk(clk), .reset(reset),
    .data_in_strobe(data_in_strobe), .data_in_start(data_in_start),
    .data_in(data_in), .data_out(data_out),
    .int_out_n(int_out_n), .int_in(int_in), .int_ack(int_ack),
    .buttons(buttons), .leds(leds), .color(color),
    .port_status(port_status), .port_out_available(port_out_available),
    .port_out_data(port_out_data), .port_in_available(port_in_available),
    .port_out_strobe(port_out_strobe), .port_in_strobe(port_in_strobe),
    .port_in_data(port_in_data),
    .menu_addr(menu_addr), .menu_data(menu_data), .cfg_vars(cfg_vars)
  );

  // Menu ROM: data follows the address one clock later.
  logic [7:0] rom [1<<AW];
  always @(posedge clk) menu_data <= rom[menu_addr];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [7:0]  m_cfg [NV];
  logic [1:0]  m_leds;
  logic [23:0] m_color;
  logic        m_coldboot, m_sys_int, m_btn_en;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic start, input logic [7:0] d);
    @(negedge clk);
    data_in_strobe = 1'b1; data_in_start = start; data_in = d;
    @(negedge clk);
    data_in_strobe = 1'b0; data_in_start = 1'b0;
  endtask

  task automatic model_reset();
    foreach (m_cfg[k]) m_cfg[k] = 8'h00;
    m_cfg[0] = 8'h01;   // "A"
    m_cfg[3] = 8'h01;   // "D"
    m_leds = 0; m_color = 0;
    m_coldboot = 1; m_sys_int = 1; m_btn_en = 1;
  endtask

  function automatic logic [8*NV-1:0] cfg_vec();
    logic [8*NV-1:0] v;
    for (int k = 0; k < NV; k++) v[8*k +: 8] = m_cfg[k];
    return v;
  endfunction

  function automatic logic [7:0] rev(input logic [7:0] x);
    return {<<{x}};
  endfunction

  function automatic logic [7:0] exp_status();
    logic [3:0] m;
    m = '0;
    for (int p = 0; p < NP; p++) m[p] = (port_out_available[8*p +: 8] != 0);
    return {m, 1'b0, !m_btn_en, (m != 0), m_coldboot};
  endfunction

  task automatic write_var(input logic [7:0] id, input logic [7:0] val);
    send(1, 8'h04); send(0, id); send(0, val);
    if (id >= 8'h41 && (id - 8'h41) < NV) m_cfg[id - 8'h41] = val;
    chk("cfg_write", cfg_vars, cfg_vec());
  endtask

  task automatic cmd6_check();
    send(1, 8'h06); send(0, 8'h00);
    chk("cmd6_status", data_out, exp_status());
    m_coldboot = 0;
  endtask

  task automatic ack_irq();
    send(1, 8'h05); send(0, 8'h01);
    @(negedge clk);
    m_sys_int = 0;
    chk("ack_clear", int_out_n, !(m_sys_int || int_in[7:1] != 0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r, b0, b1, b2, v, v2;
    logic [7:0] exp_b [8];
    logic [1:0] bt;

    reset = 1; data_in_strobe = 0; data_in_start = 0; data_in = 0;
    int_in = 0; buttons = 0; port_status = 0; port_out_available = 0;
    port_out_data = 0; port_in_available = 0;
    for (int a = 0; a < (1 << AW); a++) rom[a] = 8'($urandom);
    model_reset();
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);

    // Reset state
    chk("rst_leds", leds, 0);
    chk("rst_color", color, 0);
    chk("rst_cfg", cfg_vars, cfg_vec());
    chk("rst_data_out", data_out, 0);
    chk("rst_menu_addr", menu_addr, 0);
    chk("rst_int_ack", int_ack, 0);
    chk("rst_strobes", {port_out_strobe, port_in_strobe}, 0);
    chk("rst_int_out_n", int_out_n, 0);

    // CMD 0: id bytes, then zeros; counter saturates so byte 256+ stays zero
    send(1, 8'h00);
    for (int b = 0; b < 260; b++) begin
      send(0, 8'($urandom));
      chk("cmd0_byte", data_out, (b == 0) ? 8'h5C : (b == 1) ? 8'h42 : (b == 2) ? CID : 8'h00);
    end
    chk("cmd0_int_out_n", int_out_n, 0);

    // CMD 1: leds from byte 0 only
    r = 8'($urandom);
    send(1, 8'h01); send(0, r);
    m_leds = r[1:0];
    chk("cmd1_leds", leds, m_leds);
    send(0, ~r);
    chk("cmd1_leds_byte1", leds, m_leds);

    // CMD 2: bit-reversed colour bytes
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
    send(1, 8'h02); send(0, b0); send(0, b1); send(0, b2);
    m_color = {rev(b2), rev(b0), rev(b1)};
    chk("cmd2_color", color, m_color);

    // CMD 4: config variables with range boundaries
    write_var("C", 8'h02);
    chk("cmd4_var_c", cfg_vars[23:16], 8'h02);
    write_var("Z", 8'($urandom));
    write_var("@", 8'($urandom));
    write_var("P", 8'($urandom));
    write_var("Q", 8'($urandom));
    write_var(8'(8'h41 + $urandom_range(0, NV - 1)), 8'($urandom));

    // CMD 5: acknowledge clears sys_int one clock after the ack pulse
    send(1, 8'h05); send(0, 8'h01);
    chk("cmd5_resp0", data_out, {7'b0, m_sys_int});
    chk("cmd5_int_ack", int_ack, 8'h01);
    @(negedge clk);
    m_sys_int = 0;
    chk("cmd5_int_ack_off", int_ack, 8'h00);
    chk("cmd5_int_out_n", int_out_n, 1);
    send(0, 8'h00);
    chk("cmd5_resp1", data_out, 8'h00);
    int_in = 8'($urandom) | 8'h02;
    @(negedge clk);
    chk("int_in_level", int_out_n, 0);
    send(0, 8'h00);
    chk("cmd5_resp2", data_out, {int_in[7:1], m_sys_int});
    int_in = 0;
    @(negedge clk);
    chk("int_in_clear", int_out_n, 1);

    // CMD 6: coldboot reported once
    cmd6_check();
    cmd6_check();

    // Port 1 becomes available -> interrupt
    port_out_data = NP*8'($urandom);
    port_out_data = {8'($urandom), 8'($urandom)};
    port_out_available[15:8] = 8'd3;
    repeat (3) @(negedge clk);
    m_sys_int = 1;
    chk("port_irq", int_out_n, 0);
    cmd6_check();

    // CMD 7 sub 1, port 1, bytes 01,01,00
    send(1, 8'h07); send(0, 8'h01);
    chk("cmd7_nports", data_out, NP);
    send(0, 8'h01);
    chk("cmd7_type", data_out, 0);
    foreach (b0[i]) begin end
    for (int k = 0; k < 3; k++) begin
      v = (k < 2) ? 8'h01 : 8'h00;
      send(0, v);
      chk("cmd7_s1_data", data_out, port_out_data[15:8]);
      chk("cmd7_s1_strobe", port_out_strobe, v[0] ? 2'b10 : 2'b00);
    end

    // CMD 7 sub 0, port 0: info bytes
    port_status = {32'($urandom), 32'($urandom)};
    port_in_available = {8'($urandom), 8'($urandom)};
    exp_b[0] = port_out_available[7:0]; exp_b[1] = port_in_available[7:0];
    exp_b[2] = port_status[31:24]; exp_b[3] = port_status[23:16];
    exp_b[4] = port_status[15:8];  exp_b[5] = port_status[7:0];
    exp_b[6] = 8'h00; exp_b[7] = 8'h00;
    send(1, 8'h07); send(0, 8'h00); send(0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      send(0, 8'($urandom));
      chk("cmd7_s0_info", data_out, exp_b[k]);
    end

    // CMD 7 sub 2: port 1 write, then out-of-range port 5
    v = 8'($urandom);
    send(1, 8'h07); send(0, 8'h02); send(0, 8'h01); send(0, v);
    chk("cmd7_s2_data", port_in_data, v);
    chk("cmd7_s2_strobe", port_in_strobe, 2'b10);
    v2 = ~v;
    send(1, 8'h07); send(0, 8'h02); send(0, 8'h05); send(0, v2);
    chk("cmd7_bad_port_strobe", port_in_strobe, 2'b00);
    chk("cmd7_bad_port_data", port_in_data, v);
    chk("cmd7_bad_port_resp", data_out, 0);
    send(1, 8'h07); send(0, 8'h01); send(0, 8'h05); send(0, 8'h01);
    chk("cmd7_bad_port_out", port_out_strobe, 2'b00);
    chk("cmd7_bad_port_out_resp", data_out, 0);

    // Button interrupt, one-shot until re-armed by CMD 3
    ack_irq();
    bt = 2'($urandom_range(1, 3));
    buttons = bt;
    repeat (4) @(negedge clk);
    m_sys_int = 1; m_btn_en = 0;
    chk("btn_irq", int_out_n, 0);
    cmd6_check();
    ack_irq();
    buttons = ~bt;
    repeat (4) @(negedge clk);
    chk("btn_disarmed", int_out_n, 1);
    send(1, 8'h03); send(0, 8'h00);
    chk("cmd3_buttons", data_out, {6'b0, buttons});
    m_btn_en = 1;
    cmd6_check();
    buttons = bt;
    repeat (4) @(negedge clk);
    m_sys_int = 1; m_btn_en = 0;
    chk("btn_rearmed", int_out_n, 0);

    // CMD 8: menu walk with address wrap
    send(1, 8'h08);
    chk("cmd8_addr0", menu_addr, 0);
    for (int k = 0; k <= (1 << AW); k++) begin
      send(0, 8'($urandom));
      chk("cmd8_data", data_out, rom[k % (1 << AW)]);
    end
    chk("cmd8_wrap", menu_addr, 1);

    // Unknown command: returns zero, changes nothing
    send(1, 8'h9A);
    for (int k = 0; k < 3; k++) begin
      send(0, 8'($urandom));
      chk("unk_resp", data_out, 0);
    end
    chk("unk_leds", leds, m_leds);
    chk("unk_color", color, m_color);
    chk("unk_cfg", cfg_vars, cfg_vec());

    // Reset mid-transfer aborts the command
    send(1, 8'h01);
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    model_reset();
    send(0, 8'h03);
    chk("abort_leds", leds, 0);
    chk("abort_resp", data_out, 0);
    chk("abort_color", color, 0);
    chk("abort_cfg", cfg_vars, cfg_vec());
    send(1, 8'h01); send(0, 8'h03);
    chk("restart_leds", leds, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sysctrl_gen.md
SYSCTRL_GEN -- requirements
Module: sysctrl_gen

Interface
REQ-001 SHALL provide parameters (name, default, meaning): CORE_ID, 8'h00, core id returned by CMD 0; NUM_PORTS, 2, IO ports 1..4; NUM_VARS, 16, config variables 1..26; MENU_AW, 10, menu ROM address width.
REQ-002 SHALL provide ports (name, direction, width, meaning): clk in 1 system clock; reset in 1 asynchronous active-high reset.
REQ-003 SHALL provide the MCU link: data_in_strobe in 1; data_in_start in 1; data_in in 8; data_out out 8.
REQ-004 SHALL provide interrupt and LED ports: int_out_n out 1; int_in in 8 (bit 0 unused); int_ack out 8; buttons in 2; leds out 2; color out 24.
REQ-005 SHALL provide port inputs: port_status in 32*NUM_PORTS; port_out_available in 8*NUM_PORTS; port_out_data in 8*NUM_PORTS; port_in_available in 8*NUM_PORTS.
REQ-006 SHALL provide port outputs: port_out_strobe out NUM_PORTS; port_in_strobe out NUM_PORTS; port_in_data out 8 (shared by all ports).
REQ-007 SHALL provide menu and config ports: menu_addr out MENU_AW; menu_data in 8 (valid one clk after menu_addr); cfg_vars out 8*NUM_VARS, variable k in bits [8k+7:8k].

Function
REQ-008 SHALL act only on clk edges with data_in_strobe=1; with data_in_start=1 the cycle SHALL latch command=data_in, clear the byte counter, set menu_addr=0 and data_out=0.
REQ-009 SHALL use an 8-bit byte counter that increments on each non-start strobe and saturates at 255.
REQ-010 CMD 0 SHALL return 8'h5C, 8'h42, CORE_ID on bytes 0..2.
REQ-011 CMD 1 SHALL load leds from byte 0 bits [1:0].
REQ-012 CMD 2 SHALL load bit-reversed bytes 0,1,2 into color[15:8], color[7:0], color[23:16] respectively.
REQ-013 CMD 3 SHALL return {6'b0, buttons} on every byte and re-arm the button interrupt.
REQ-014 CMD 4 byte 0 SHALL latch id; byte 1 SHALL write data_in to variable k=id-"A" when 0<=k<NUM_VARS, otherwise no variable SHALL change.
REQ-015 CMD 5 byte 0 SHALL drive int_ack=data_in for exactly one clk; every byte SHALL return {int_in[7:1], sys_int}.
REQ-016 CMD 6 SHALL return {port_avail_mask[3:0], 1'b0, !button_irq_enable, |port_avail_mask, coldboot}, unused mask bits 0; byte 0 SHALL clear coldboot.
REQ-017 CMD 7 byte 0 SHALL latch the subcommand and return NUM_PORTS; byte 1 SHALL latch the port index and return 0 (serial type).
REQ-018 For CMD 7 with port index >= NUM_PORTS, bytes 2+ SHALL return 0 and raise no strobes.
REQ-019 CMD 7 sub 0 SHALL return, for bytes 2..7: out_available, in_available, status[31:24], [23:16], [15:8], [7:0] of the selected port; 0 thereafter.
REQ-020 CMD 7 sub 1 SHALL return port_out_data of the selected port and pulse that port's port_out_strobe for one clk iff data_in[0]=1.
REQ-021 CMD 7 sub 2 SHALL load port_in_data=data_in and pulse that port's port_in_strobe for one clk.
REQ-022 CMD 8 SHALL return menu_data and increment menu_addr modulo 2^MENU_AW on each byte.
REQ-023 Unknown commands SHALL return 0 and change no state.
REQ-024 sys_int SHALL set on: any port's out_available going zero to nonzero; a change between the two button synchroniser stages while button_irq_enable=1 (which also clears button_irq_enable).
REQ-025 int_ack[0] SHALL clear sys_int one clk after the ack cycle; a coincident set event SHALL win.
REQ-026 int_out_n SHALL be 0 while sys_int=1 or int_in[7:1]!=0, else 1.

Reset
REQ-027 Asynchronous reset SHALL set: leds=0, color=0, int_ack=0, all strobes=0, data_out=0, menu_addr=0, byte counter=0, coldboot=1, sys_int=1, button_irq_enable=1, cfg_vars all 0 except variable "A"=8'h01 and "D"=8'h01.
REQ-028 Reset mid-transfer SHALL abort the command; the next transfer SHALL require data_in_start.

Verification
REQ-029 Reset then CMD 0 with 3 bytes, CORE_ID=8'h07 -> data_out 8'h5C, 8'h42, 8'h07; int_out_n=0.
REQ-030 CMD 5 with ack 8'h01, int_in=0 -> sys_int=0, int_out_n=1; a later CMD 6 byte 0 returns bit0=1, the next CMD 6 returns bit0=0.
REQ-031 CMD 4 id "C" value 8'h02 -> cfg_vars[23:16]=8'h02; id "Z" with NUM_VARS=16 -> cfg_vars unchanged.
REQ-032 Port 1 out_available 0->3 -> sys_int=1; CMD 6 returns bit5=1; CMD 7 sub 1, port 1, bytes 01,01,00 -> two port_out_strobe[1] pulses, no strobe on port 0.
REQ-033 CMD 7 sub 2, port index 5 -> no port_in_strobe; CMD 8 across 2^MENU_AW+1 bytes -> menu_addr wraps to 1.
